// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding ID.
// Owns the fetch PC, issues in-order imem reads under a credit limit, buffers
// returned words with their PC in a small FIFO, and applies EX/ID redirects,
// dropping responses that belong to the abandoned path.
// Optional feature: define IF_PERF_CNT_EN to add perf_fetch_cnt/perf_drop_cnt.

module if_fetch_chk #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_data_valid,
   input  logic [CW-1:0] in_flight_q
);
   // A response while nothing is outstanding means imem broke the protocol
   a_resp_has_credit: assert property (@(posedge clk) disable iff (reset)
      i_data_valid |-> (in_flight_q != '0));
endmodule

module if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] i_address,
   output logic        i_read_req,
   input  logic        i_req_ready,
   input  logic [31:0] i_data_read,
   input  logic        i_data_valid,
   input  logic        nullify,
   input  logic [31:0] pc_in_EX,
   input  logic        Pc_cmd_id,
   input  logic [31:0] pc_in_ID,
   input  logic        id_ready,
   output logic [31:0] instr_ID,
   output logic [31:0] PC_ID,
   output logic        valid_ID
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] in_flight_q, in_flight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
   logic [PW-1:0] ifq_rd_q, ifq_rd_d, ifq_wr_q, ifq_wr_d;
   logic [31:0]   fifo_instr_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]   ifq_pc_q     [FIFO_DEPTH];
   logic          empty_s, credit_s, id_redir_s, redirect_s;
   logic          accept_s, push_s, pop_s;

   // Present the FIFO head to ID and decide issue/redirect for this cycle
   always_comb begin
      empty_s  = (fifo_cnt_q == '0);
      valid_ID = !empty_s && !nullify;
      if (!empty_s) begin
         instr_ID = fifo_instr_q[fifo_rd_q];
         PC_ID    = fifo_pc_q[fifo_rd_q];
      end else begin
         instr_ID = 32'h0000_0000;
         PC_ID    = 32'h0000_0000;
      end
      // valid_ID already excludes nullify, so EX always wins over ID
      id_redir_s = Pc_cmd_id && valid_ID && id_ready;
      redirect_s = nullify || id_redir_s;
      credit_s   = (({1'b0, in_flight_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
      i_read_req = credit_s && !redirect_s && !reset;
      i_address  = pc_q;
      accept_s   = i_read_req && i_req_ready;
      push_s     = i_data_valid && (drop_q == '0) && !redirect_s;
      pop_s      = valid_ID && id_ready && !redirect_s;
   end

   // Next-state for PC, credit/drop counters and both queue pointers
   always_comb begin
      in_flight_d = in_flight_q + CW'(accept_s) - CW'(i_data_valid);
      ifq_wr_d    = ifq_wr_q + PW'(accept_s);
      ifq_rd_d    = ifq_rd_q + PW'(i_data_valid);
      if (nullify) begin
         pc_d = pc_in_EX & 32'hFFFF_FFFC;
      end else if (id_redir_s) begin
         pc_d = pc_in_ID & 32'hFFFF_FFFC;
      end else if (accept_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
      if (redirect_s) begin
         // Every outstanding response is now wrong-path; one arriving now is consumed here
         drop_d     = in_flight_q - CW'(i_data_valid);
         fifo_cnt_d = '0;
         fifo_rd_d  = '0;
         fifo_wr_d  = '0;
      end else begin
         if (i_data_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1'b1);
         end else begin
            drop_d = drop_q;
         end
         fifo_cnt_d = fifo_cnt_q + CW'(push_s) - CW'(pop_s);
         fifo_rd_d  = fifo_rd_q + PW'(pop_s);
         fifo_wr_d  = fifo_wr_q + PW'(push_s);
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC & 32'hFFFF_FFFC;
         in_flight_q <= '0;
         drop_q      <= '0;
         fifo_cnt_q  <= '0;
         fifo_rd_q   <= '0;
         fifo_wr_q   <= '0;
         ifq_rd_q    <= '0;
         ifq_wr_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         in_flight_q <= in_flight_d;
         drop_q      <= drop_d;
         fifo_cnt_q  <= fifo_cnt_d;
         fifo_rd_q   <= fifo_rd_d;
         fifo_wr_q   <= fifo_wr_d;
         ifq_rd_q    <= ifq_rd_d;
         ifq_wr_q    <= ifq_wr_d;
      end
   end

   // Storage arrays hold data only; occupancy lives in the reset counters above
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_instr_q[fifo_wr_q] <= i_data_read;
         fifo_pc_q[fifo_wr_q]    <= ifq_pc_q[ifq_rd_q];
      end
      if (accept_s) begin
         ifq_pc_q[ifq_wr_q] <= pc_q;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_drop_q, flushed_s;
   logic        drop_resp_s;

   // Words discarded this cycle: wrong-path responses plus flushed FIFO entries
   always_comb begin
      drop_resp_s = i_data_valid && ((drop_q != '0) || redirect_s);
      if (nullify) begin
         flushed_s = 32'(fifo_cnt_q);
      end else if (id_redir_s) begin
         flushed_s = 32'(fifo_cnt_q) - 32'd1;
      end else begin
         flushed_s = 32'd0;
      end
   end

   // Free-running performance counters, wrapping at 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_q <= 32'd0;
         perf_drop_q  <= 32'd0;
      end else begin
         perf_fetch_q <= perf_fetch_q + 32'(accept_s);
         perf_drop_q  <= perf_drop_q + flushed_s + 32'(drop_resp_s);
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_drop_cnt  = perf_drop_q;
`endif

   if_fetch_chk #(.CW(CW)) u_chk (
      .clk          (clk),
      .reset        (reset),
      .i_data_valid (i_data_valid),
      .in_flight_q  (in_flight_q)
   );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed scenarios push the expected PC
// stream into a queue; a monitor compares every word ID consumes.

module tb_if_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read_req;
   logic        i_req_ready;
   logic [31:0] i_data_read;
   logic        i_data_valid;
   logic        nullify;
   logic [31:0] pc_in_EX;
   logic        Pc_cmd_id;
   logic [31:0] pc_in_ID;
   logic        id_ready;
   logic [31:0] instr_ID;
   logic [31:0] PC_ID;
   logic        valid_ID;

   logic [31:0] exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] acc_log[$];
   int          ws = 0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   if_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .i_address    (i_address),
      .i_read_req   (i_read_req),
      .i_req_ready  (i_req_ready),
      .i_data_read  (i_data_read),
      .i_data_valid (i_data_valid),
      .nullify      (nullify),
      .pc_in_EX     (pc_in_EX),
      .Pc_cmd_id    (Pc_cmd_id),
      .pc_in_ID     (pc_in_ID),
      .id_ready     (id_ready),
      .instr_ID     (instr_ID),
      .PC_ID        (PC_ID),
      .valid_ID     (valid_ID)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1300_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ID consumes until the scoreboard is empty, then stops; bounded wait
   task automatic drain(input string name);
      int n;
      n = 0;
      id_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      id_ready = 1'b0;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_timeout: %0d words still expected, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // imem model: accepts on the sampled handshake, answers after 1+ws cycles, in order
   initial begin
      i_req_ready  = 1'b1;
      i_data_valid = 1'b0;
      i_data_read  = 32'h0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            i_data_valid = 1'b1;
            i_data_read  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            i_data_valid = 1'b0;
            i_data_read  = 32'h0;
         end
         @(negedge clk);
         if (reset) begin
            pend_addr.delete();
            pend_due.delete();
         end else if (i_read_req && i_req_ready) begin
            pend_addr.push_back(i_address);
            pend_due.push_back(cyc + 1 + ws);
            acc_log.push_back(i_address);
         end
      end
   end

   // Monitor: every word handed to ID must match the scoreboard head
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (valid_ID && id_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_output: got PC_ID=%h, expected no output", PC_ID);
            end else begin
               e = exp_q.pop_front();
               if (PC_ID !== e || instr_ID !== mem_word(e)) begin
                  miscompares++;
                  $display("FAIL pc_instr: got PC_ID=%h instr_ID=%h, expected %h/%h",
                           PC_ID, instr_ID, e, mem_word(e));
               end
            end
         end
      end
   end

   initial begin
      int n;
      int hits;
      reset = 1'b1; nullify = 1'b0; pc_in_EX = 32'h0;
      Pc_cmd_id = 1'b0; pc_in_ID = 32'h0; id_ready = 1'b0;
      cycles(3);
      chk("rst_req",   32'(i_read_req), 32'h0);
      chk("rst_valid", 32'(valid_ID),   32'h0);
      chk("rst_instr", instr_ID,        32'h0);
      chk("rst_pc",    PC_ID,           32'h0);

      // 1: straight-line fetch from RESET_PC
      reset = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      drain("t1");
      chk("t1_first_addr", acc_log[0], 32'h0);

      // 2: ID stalls, FIFO holds 0x8/0xC and issue stops
      cycles(6);
      chk("t2_req_stalled", 32'(i_read_req), 32'h0);
      chk("t2_valid",       32'(valid_ID),   32'h1);
      chk("t2_head_pc",     PC_ID,           32'h8);
      chk("t2_head_instr",  instr_ID,        mem_word(32'h8));
      exp_q.push_back(32'h8); exp_q.push_back(32'hC); exp_q.push_back(32'h10);
      drain("t2");

      // 3: nullify with two requests in flight; both responses are dropped
      cycles(4);
      ws = 5;
      exp_q.push_back(32'h14); exp_q.push_back(32'h18);
      drain("t3a");
      n = 0;
      while (pend_addr.size() < 2 && n < 50) begin cycles(1); n++; end
      chk("t3_in_flight", 32'(pend_addr.size()), 32'd2);
      acc_log.delete();
      nullify = 1'b1; pc_in_EX = 32'h0000_0102;
      #1;
      chk("t3_req_during_null", 32'(i_read_req), 32'h0);
      cycles(1);
      nullify = 1'b0;
      ws = 0;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      drain("t3b");
      chk("t3_redirect_addr", acc_log[0], 32'h100);

      // 4: ID jump at head 0x108 -> head consumed, 0x10C flushed, then 0x40
      cycles(4);
      chk("t4_head_pc", PC_ID, 32'h108);
      acc_log.delete();
      exp_q.push_back(32'h108); exp_q.push_back(32'h40); exp_q.push_back(32'h44);
      id_ready = 1'b1; Pc_cmd_id = 1'b1; pc_in_ID = 32'h40;
      cycles(1);
      Pc_cmd_id = 1'b0;
      drain("t4");
      chk("t4_redirect_addr", acc_log[0], 32'h40);

      // 5: nullify and ID jump together; EX target wins, head not consumed
      cycles(4);
      chk("t5_head_pc", PC_ID, 32'h48);
      acc_log.delete();
      nullify = 1'b1; pc_in_EX = 32'h200;
      Pc_cmd_id = 1'b1; pc_in_ID = 32'h40; id_ready = 1'b1;
      #1;
      chk("t5_valid_masked", 32'(valid_ID), 32'h0);
      cycles(1);
      nullify = 1'b0; Pc_cmd_id = 1'b0;
      exp_q.push_back(32'h200); exp_q.push_back(32'h204);
      drain("t5");
      chk("t5_redirect_addr", acc_log[0], 32'h200);
      hits = 0;
      foreach (acc_log[i]) if (acc_log[i] == 32'h40) hits++;
      chk("t5_no_0x40_fetch", 32'(hits), 32'h0);

      // 6: slow imem, reset pulsed while fetches are outstanding
      ws = 3;
      cycles(4);
      exp_q.push_back(32'h208); exp_q.push_back(32'h20C);
      drain("t6a");
      n = 0;
      while (pend_addr.size() == 0 && n < 50) begin cycles(1); n++; end
      chk("t6_in_flight", 32'(pend_addr.size() > 0), 32'h1);
      #2;
      reset = 1'b1;
      acc_log.delete();
      #1;
      chk("t6_rst_req",   32'(i_read_req), 32'h0);
      chk("t6_rst_valid", 32'(valid_ID),   32'h0);
      chk("t6_rst_instr", instr_ID,        32'h0);
      chk("t6_rst_pc",    PC_ID,           32'h0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      drain("t6b");
      chk("t6_restart_addr", acc_log[0], 32'h0);

      cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
